// File: rtl/pcunit_stack.sv
// Program counter with conditional relative branches, a LIFO return stack for
// CALL/RET, and a single-level interrupt save/restore of PC and flags.
module pcunit_stack #(
  parameter int AW      = 12,
  parameter int DW      = 8,
  parameter int DEPTH   = 8,
  parameter int INT_VEC = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clk_en_i,
  input  logic [3:0]                 pc_oper_i,
  input  logic [AW-1:0]              addr_i,
  input  logic [DW-1:0]              disp_i,
  input  logic                       pc_en_i,
  input  logic                       int_i,
  input  logic                       cc_c_i,
  input  logic                       cc_z_i,
  input  logic                       err_clr_i,
  output logic [AW-1:0]              inst_addr_o,
  output logic                       intc_o,
  output logic                       intz_o,
  output logic                       int_active_o,
  output logic [$clog2(DEPTH):0]     stack_lvl_o,
  output logic                       stack_ovf_o,
  output logic                       stack_unf_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  localparam logic [3:0] OP_INT  = 4'b0001;
  localparam logic [3:0] OP_BZ   = 4'b0100;
  localparam logic [3:0] OP_BNZ  = 4'b0101;
  localparam logic [3:0] OP_BC   = 4'b0110;
  localparam logic [3:0] OP_BNC  = 4'b0111;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_CALL = 4'b1100;
  localparam logic [3:0] OP_RET  = 4'b1010;
  localparam logic [3:0] OP_RETI = 4'b1011;

  logic [AW-1:0] pc_q, int_pc_q;
  logic [LW-1:0] lvl_q;
  logic          ovf_q, unf_q, act_q, intc_q, intz_q;
  logic [AW-1:0] stack_mem [DEPTH];

  logic [AW-1:0] pc_inc, disp_ext, br_tgt, pc_next;
  logic [IW-1:0] wr_idx, top_idx;
  logic          full, empty;
  logic          push, pop, ovf_set, unf_set, reti, int_take;

  assign pc_inc   = pc_q + AW'(1);
  assign disp_ext = AW'($signed(disp_i));
  assign br_tgt   = pc_inc + disp_ext;
  assign full     = (lvl_q == LW'(DEPTH));
  assign empty    = (lvl_q == '0);
  assign wr_idx   = lvl_q[IW-1:0];
  assign top_idx  = IW'(lvl_q - LW'(1));

  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    reti    = 1'b0;
    if (pc_en_i) begin
      case (pc_oper_i)
        OP_INT:  pc_next = AW'(INT_VEC);
        OP_BZ:   if (cc_z_i)  pc_next = br_tgt;
        OP_BNZ:  if (!cc_z_i) pc_next = br_tgt;
        OP_BC:   if (cc_c_i)  pc_next = br_tgt;
        OP_BNC:  if (!cc_c_i) pc_next = br_tgt;
        OP_JMP:  pc_next = addr_i;
        OP_CALL: begin
          pc_next = addr_i;
          if (full) ovf_set = 1'b1;
          else      push    = 1'b1;
        end
        OP_RET: begin
          if (empty) unf_set = 1'b1;
          else begin
            pop     = 1'b1;
            pc_next = stack_mem[top_idx];
          end
        end
        OP_RETI: begin
          pc_next = int_pc_q;
          reti    = 1'b1;
        end
        default: pc_next = pc_inc;
      endcase
    end
  end

  // A RETI in the same cycle frees the single save slot for a new interrupt.
  assign int_take = int_i & (~act_q | reti);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q     <= '0;
      int_pc_q <= '0;
      lvl_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      act_q    <= 1'b0;
      intc_q   <= 1'b0;
      intz_q   <= 1'b0;
    end else if (clk_en_i) begin
      if (pc_en_i) pc_q <= pc_next;
      if (push)     lvl_q <= lvl_q + LW'(1);
      else if (pop) lvl_q <= lvl_q - LW'(1);
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (unf_set)        unf_q <= 1'b1;
      else if (err_clr_i) unf_q <= 1'b0;
      if (int_take) begin
        int_pc_q <= pc_q;
        intc_q   <= cc_c_i;
        intz_q   <= cc_z_i;
        act_q    <= 1'b1;
      end else if (reti) begin
        act_q    <= 1'b0;
      end
    end
  end

  // Stack entries carry no reset; only entries below the level are ever read.
  always_ff @(posedge clk_i) begin
    if (clk_en_i && push) stack_mem[wr_idx] <= pc_inc;
  end

  assign inst_addr_o  = pc_q;
  assign intc_o       = intc_q;
  assign intz_o       = intz_q;
  assign int_active_o = act_q;
  assign stack_lvl_o  = lvl_q;
  assign stack_ovf_o  = ovf_q;
  assign stack_unf_o  = unf_q;

endmodule

// File: doc/pcunit_stack.md
PCUNIT_STACK -- requirements
Module: pcunit_stack

Interface
REQ-001 Parameter AW, default 12: instruction address width in bits.
REQ-002 Parameter DW, default 8: branch displacement width in bits.
REQ-003 Parameter DEPTH, default 8: return-stack entries, a power of 2 and at least 2.
REQ-004 Parameter INT_VEC, default 1: interrupt vector address (AW bits).
REQ-005 Ports (name direction width meaning):
- clk_i in 1: single clock, rising edge.
- rst_ni in 1: reset, asynchronous assert, active-low.
- clk_en_i in 1: global clock enable. No state changes when 0.
- pc_oper_i in 4: PC operation code.
- addr_i in AW: absolute jump/call target.
- disp_i in DW: signed branch displacement.
- pc_en_i in 1: PC/stack update enable.
- int_i in 1: interrupt accept strobe.
- cc_c_i in 1: carry condition code.
- cc_z_i in 1: zero condition code.
- err_clr_i in 1: clears sticky error flags.
- inst_addr_o out AW: current PC.
- intc_o out 1: saved carry flag.
- intz_o out 1: saved zero flag.
- int_active_o out 1: interrupt in service.
- stack_lvl_o out $clog2(DEPTH)+1: occupied stack entries.
- stack_ovf_o out 1: sticky push-when-full flag.
- stack_unf_o out 1: sticky pop-when-empty flag.

Function
REQ-006 "Update cycle" means a rising clk_i edge with clk_en_i=1. Every register holds its value on all other edges.
REQ-007 PC updates only on an update cycle with pc_en_i=1. Next PC, all arithmetic modulo 2^AW:
- 0000 INC: PC+1.
- 0001 INT: INT_VEC.
- 0100 BZ: PC+1+sext(disp) if cc_z_i=1, else PC+1.
- 0101 BNZ: same target if cc_z_i=0, else PC+1.
- 0110 BC: same target if cc_c_i=1, else PC+1.
- 0111 BNC: same target if cc_c_i=0, else PC+1.
- 1000 JMP: addr_i.
- 1100 CALL: push PC+1, then PC=addr_i.
- 1010 RET: pop, then PC=popped value.
- 1011 RETI: PC=saved interrupt PC, clear int_active_o.
- All other codes: treated as INC.
REQ-008 sext means disp_i sign-extended to AW bits. Wrap-around past 2^AW-1 to 0, or below 0, SHALL not be flagged.
REQ-009 The return stack is LIFO, DEPTH entries. stack_lvl_o ranges 0..DEPTH. Push and pop change stack_lvl_o by 1 in the same update cycle.
REQ-010 CALL when stack_lvl_o=DEPTH: the push is discarded, stack contents and level are unchanged, stack_ovf_o is set to 1, and PC=addr_i anyway.
REQ-011 RET when stack_lvl_o=0: stack_unf_o is set to 1, the level stays 0, and PC=PC+1.
REQ-012 On an update cycle with int_i=1, the block SHALL save:
- saved interrupt PC = current inst_addr_o;
- intc_o = cc_c_i and intz_o = cc_z_i;
- int_active_o = 1.
This is independent of pc_en_i.
REQ-013 int_i=1 while int_active_o=1: the save is ignored and saved state is unchanged (single-level interrupt).
REQ-014 int_i=1 and RETI in the same update cycle: RETI executes first, then the new save is accepted. int_active_o stays 1, and the saved PC is the pre-RETI inst_addr_o.
REQ-015 err_clr_i=1 on an update cycle clears stack_ovf_o and stack_unf_o. A new error in the same cycle takes priority, and that flag reads 1.
REQ-016 No combinational path from any input to any output. All outputs come directly from registers or the stack-level counter.

Reset
REQ-017 When rst_ni=0, immediately and regardless of clk_en_i:
- inst_addr_o=0;
- stack_lvl_o=0;
- stack_ovf_o=0, stack_unf_o=0;
- int_active_o=0, intc_o=0, intz_o=0;
- saved interrupt PC=0.
REQ-018 Stack entry contents SHALL not be reset and are unobservable until written.
REQ-019 Reset asserted mid-operation aborts any pending update. The first update cycle after deassertion starts from PC=0.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then 3 update cycles of INC with pc_en_i=1 -> inst_addr_o=0,1,2,3. clk_en_i=0 for 2 cycles -> holds at 3.
- PC=0x010, BZ, disp=0xFE, cc_z_i=1 -> 0x00F. Same with cc_z_i=0 -> 0x011. PC=0xFFF, INC -> 0x000.
- 8 nested CALLs to 0x100+n -> stack_lvl_o=8. 9th CALL to 0x200 -> PC=0x200, stack_ovf_o=1, level 8. 8 RETs -> return addresses in reverse order. 9th RET -> stack_unf_o=1, PC=PC+1. err_clr_i -> both flags 0.
- PC=0x055, int_i=1 with cc_c_i=1, cc_z_i=0, plus INT -> PC=0x001, int_active_o=1, intc_o=1, intz_o=0. Second int_i -> ignored. RETI -> PC=0x055, int_active_o=0.
- RETI and int_i in the same cycle -> PC=saved PC, int_active_o stays 1, new saved PC = pre-RETI PC.
- rst_ni pulsed low between clock edges mid-CALL sequence -> all outputs zero immediately, stack_lvl_o=0.
